// File: rtl/cdc_handshake_source.sv
// -----------------------------------------------------------------------------
// cdc_handshake_source
//
// Source-side controller for a four-phase req/ack handshake. It moves one
// DATA_WIDTH word from the i_clock domain into another clock domain. A word
// is accepted on a valid/ready interface and held on o_data. o_req is then
// sequenced against the asynchronous acknowledge i_ack. i_ack is resynchronised
// through a FF_STAGES flop chain before the FSM uses it. When TIMEOUT_CYCLES
// is non-zero, a handshake phase that stalls for too long is aborted.
//
// Parameters:
//   DATA_WIDTH     width of the transferred word
//   FF_STAGES      synchronizer depth for i_ack (>= 2)
//   TIMEOUT_CYCLES per-phase ack wait limit in cycles, 0 disables the timeout
//
// Ports:
//   i_clock    in   sole clock, rising edge
//   i_reset    in   synchronous active-high reset
//   i_valid    in   source word available
//   i_data     in   source word
//   o_ready    out  word can be accepted this cycle
//   o_req      out  handshake request to the destination domain
//   o_data     out  held word, stable whenever o_req=1
//   i_ack      in   asynchronous acknowledge from the destination domain
//   o_done     out  one-cycle pulse when a handshake completes
//   o_timeout  out  one-cycle pulse when a phase is aborted by the timeout
// -----------------------------------------------------------------------------
module cdc_handshake_source #(
    parameter int DATA_WIDTH     = 8,
    parameter int FF_STAGES      = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_req,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ack,
    output logic                  o_done,
    output logic                  o_timeout
);

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int SETTLE_W   = $clog2(FF_STAGES + 1);
    // A zero-width counter is illegal, so the disabled case keeps one unused bit.
    localparam int PHASE_W    = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(FF_STAGES);
    localparam logic [PHASE_W-1:0]  PHASE_LIMIT = PHASE_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_RECOVER  = 2'd0,
        ST_IDLE     = 2'd1,
        ST_REQ_HIGH = 2'd2,
        ST_REQ_LOW  = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [FF_STAGES-1:0]    sync_r;
    logic                    ack_s;
    logic [SETTLE_W-1:0]     settle_r;
    logic [SETTLE_W-1:0]     settle_nxt_s;
    logic [PHASE_W-1:0]      phase_r;
    logic [PHASE_W-1:0]      phase_nxt_s;
    logic [PHASE_W-1:0]      phase_inc_s;
    logic                    phase_expired_s;
    logic [DATA_WIDTH-1:0]   data_nxt_s;
    logic                    done_nxt_s;
    logic                    timeout_nxt_s;

    assign ack_s           = sync_r[FF_STAGES-1];
    assign phase_inc_s     = phase_r + PHASE_W'(1);
    assign phase_expired_s = TIMEOUT_EN && (phase_inc_s == PHASE_LIMIT);

    // Synchronizer for the asynchronous acknowledge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[FF_STAGES-2:0], i_ack};
        end
    end

    // Next-state, counter and output-pulse decode.
    always_comb begin
        state_nxt_s   = state_r;
        settle_nxt_s  = settle_r;
        phase_nxt_s   = phase_r;
        data_nxt_s    = o_data;
        done_nxt_s    = 1'b0;
        timeout_nxt_s = 1'b0;

        case (state_r)
            ST_RECOVER: begin
                // The settle counter makes sure flops cleared by reset have
                // been refilled from i_ack before ack_s is trusted as low.
                if (settle_r < SETTLE_DONE) begin
                    settle_nxt_s = settle_r + SETTLE_W'(1);
                end else begin
                    settle_nxt_s = settle_r;
                end
                if ((settle_r >= SETTLE_DONE) && !ack_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RECOVER;
                end
            end

            ST_IDLE: begin
                if (i_valid) begin
                    data_nxt_s  = i_data;
                    phase_nxt_s = '0;
                    state_nxt_s = ST_REQ_HIGH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_REQ_HIGH: begin
                // When an exit and a timeout happen in the same cycle, the exit takes priority.
                if (ack_s) begin
                    phase_nxt_s = '0;
                    state_nxt_s = ST_REQ_LOW;
                end else if (phase_expired_s) begin
                    timeout_nxt_s = 1'b1;
                    settle_nxt_s  = '0;
                    phase_nxt_s   = '0;
                    state_nxt_s   = ST_RECOVER;
                end else if (TIMEOUT_EN) begin
                    phase_nxt_s = phase_inc_s;
                end else begin
                    phase_nxt_s = phase_r;
                end
            end

            ST_REQ_LOW: begin
                if (!ack_s) begin
                    done_nxt_s  = 1'b1;
                    phase_nxt_s = '0;
                    state_nxt_s = ST_IDLE;
                end else if (phase_expired_s) begin
                    timeout_nxt_s = 1'b1;
                    settle_nxt_s  = '0;
                    phase_nxt_s   = '0;
                    state_nxt_s   = ST_RECOVER;
                end else if (TIMEOUT_EN) begin
                    phase_nxt_s = phase_inc_s;
                end else begin
                    phase_nxt_s = phase_r;
                end
            end

            default: begin
                settle_nxt_s = '0;
                phase_nxt_s  = '0;
                state_nxt_s  = ST_RECOVER;
            end
        endcase
    end

    // State, counters and registered outputs.
    // o_ready and o_req are decoded from the next state, so they line up with the state they describe.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r   <= ST_RECOVER;
            settle_r  <= '0;
            phase_r   <= '0;
            o_data    <= '0;
            o_ready   <= 1'b0;
            o_req     <= 1'b0;
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            settle_r  <= settle_nxt_s;
            phase_r   <= phase_nxt_s;
            o_data    <= data_nxt_s;
            o_ready   <= (state_nxt_s == ST_IDLE);
            o_req     <= (state_nxt_s == ST_REQ_HIGH);
            o_done    <= done_nxt_s;
            o_timeout <= timeout_nxt_s;
        end
    end

endmodule

// File: tb/tb_cdc_handshake_source.sv
// -----------------------------------------------------------------------------
// tb_cdc_handshake_source
//
// Directed bench for cdc_handshake_source with FF_STAGES=2. There are three
// instances: index 0 has no timeout, index 1 has TIMEOUT_CYCLES=8 and index 2
// has TIMEOUT_CYCLES=4. The instances share the clock and reset, and each has
// its own data and handshake signals. Inputs are driven and outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_cdc_handshake_source;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid [3];
    logic [7:0] data  [3];
    logic       ack   [3];
    logic       ready [3];
    logic       req   [3];
    logic [7:0] dout  [3];
    logic       done  [3];
    logic       tout  [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cdc_handshake_source #(.DATA_WIDTH(8), .FF_STAGES(2), .TIMEOUT_CYCLES(0)) u_dut_t0 (
        .i_clock(clk), .i_reset(rst), .i_valid(valid[0]), .i_data(data[0]),
        .o_ready(ready[0]), .o_req(req[0]), .o_data(dout[0]), .i_ack(ack[0]),
        .o_done(done[0]), .o_timeout(tout[0])
    );

    cdc_handshake_source #(.DATA_WIDTH(8), .FF_STAGES(2), .TIMEOUT_CYCLES(8)) u_dut_t8 (
        .i_clock(clk), .i_reset(rst), .i_valid(valid[1]), .i_data(data[1]),
        .o_ready(ready[1]), .o_req(req[1]), .o_data(dout[1]), .i_ack(ack[1]),
        .o_done(done[1]), .o_timeout(tout[1])
    );

    cdc_handshake_source #(.DATA_WIDTH(8), .FF_STAGES(2), .TIMEOUT_CYCLES(4)) u_dut_t4 (
        .i_clock(clk), .i_reset(rst), .i_valid(valid[2]), .i_data(data[2]),
        .o_ready(ready[2]), .o_req(req[2]), .o_data(dout[2]), .i_ack(ack[2]),
        .o_done(done[2]), .o_timeout(tout[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] words [3];

    initial begin
        int  idx;
        int  done_cnt;
        bit  acc;

        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;

        // ---------------- reset and release ----------------
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0;
            data[k]  = 8'h00;
            ack[k]   = 1'b0;
        end
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_ready", 32'(ready[k]), 32'd0);
            check_eq("rst_req",   32'(req[k]),   32'd0);
            check_eq("rst_data",  32'(dout[k]),  32'd0);
            check_eq("rst_done",  32'(done[k]),  32'd0);
            check_eq("rst_tout",  32'(tout[k]),  32'd0);
        end
        rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) check_eq("settle_c1_ready", 32'(ready[k]), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) check_eq("settle_c2_ready", 32'(ready[k]), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            check_eq("settle_c3_ready", 32'(ready[k]), 32'd1);
            check_eq("settle_c3_req",   32'(req[k]),   32'd0);
            check_eq("settle_c3_done",  32'(done[k]),  32'd0);
        end

        // ---------------- single transfer 0xA5 (dut 0) ----------------
        valid[0] = 1'b1;
        data[0]  = 8'hA5;
        tick();                                   // accept edge N
        valid[0] = 1'b0;
        data[0]  = 8'h00;
        check_eq("acc_req",   32'(req[0]),   32'd1);
        check_eq("acc_ready", 32'(ready[0]), 32'd0);
        check_eq("acc_data",  32'(dout[0]),  32'hA5);
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 3) ack[0] = 1'b1;            // ack rises 3 cycles after req
            check_eq("reqhi_req",  32'(req[0]),  32'd1);
            check_eq("reqhi_data", 32'(dout[0]), 32'hA5);
        end
        tick();                                   // N+6: req falls
        check_eq("reqlo_req",  32'(req[0]),  32'd0);
        check_eq("reqlo_data", 32'(dout[0]), 32'hA5);
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 3) ack[0] = 1'b0;            // ack drops 3 cycles after req falls
            check_eq("reqlo_done",  32'(done[0]),  32'd0);
            check_eq("reqlo_ready", 32'(ready[0]), 32'd0);
        end
        tick();
        check_eq("xfer_done",  32'(done[0]),  32'd1);
        check_eq("xfer_ready", 32'(ready[0]), 32'd1);
        check_eq("xfer_data",  32'(dout[0]),  32'hA5);
        tick();
        check_eq("xfer_done_pulse", 32'(done[0]),  32'd0);
        check_eq("xfer_idle_ready", 32'(ready[0]), 32'd1);

        // ---------------- streaming 0x01,0x02,0x03 (dut 0) ----------------
        idx      = 0;
        done_cnt = 0;
        valid[0] = 1'b1;
        data[0]  = words[0];
        for (int cyc = 0; cyc < 100 && done_cnt < 3; cyc++) begin
            acc = ready[0] && valid[0];
            tick();
            ack[0] = req[0];                      // destination answers immediately
            if (done[0]) done_cnt++;
            if (acc) begin
                check_eq("stream_word", 32'(dout[0]), 32'(words[idx]));
                idx++;
                if (idx >= 3) begin
                    valid[0] = 1'b0;
                end else begin
                    data[0] = words[idx];
                end
            end
        end
        repeat (10) begin
            tick();
            ack[0] = req[0];
            if (done[0]) done_cnt++;
        end
        check_eq("stream_accepts", 32'(idx),      32'd3);
        check_eq("stream_dones",   32'(done_cnt), 32'd3);
        check_eq("stream_last",    32'(dout[0]),  32'h03);
        check_eq("stream_ready",   32'(ready[0]), 32'd1);

        // ---------------- no timeout when disabled (dut 0) ----------------
        ack[0]   = 1'b0;
        valid[0] = 1'b1;
        data[0]  = 8'h77;
        tick();
        valid[0] = 1'b0;
        repeat (20) tick();
        check_eq("t0_stuck_req",  32'(req[0]),  32'd1);
        check_eq("t0_stuck_tout", 32'(tout[0]), 32'd0);
        check_eq("t0_stuck_data", 32'(dout[0]), 32'h77);

        // ---------------- timeout 8, ack stuck low (dut 1) ----------------
        valid[1] = 1'b1;
        data[1]  = 8'h3C;
        tick();                                   // REQ_HIGH entry edge
        valid[1] = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_eq("t8_wait_tout", 32'(tout[1]), 32'd0);
            check_eq("t8_wait_req",  32'(req[1]),  32'd1);
        end
        tick();                                   // entry + 8
        check_eq("t8_tout",  32'(tout[1]), 32'd1);
        check_eq("t8_req",   32'(req[1]),  32'd0);
        check_eq("t8_done",  32'(done[1]), 32'd0);
        check_eq("t8_data",  32'(dout[1]), 32'h3C);
        tick();
        check_eq("t8_tout_pulse", 32'(tout[1]),  32'd0);
        check_eq("t8_rec1_ready", 32'(ready[1]), 32'd0);
        tick();
        check_eq("t8_rec2_ready", 32'(ready[1]), 32'd0);
        tick();
        check_eq("t8_rec3_ready", 32'(ready[1]), 32'd1);

        // ---------------- timeout 4 boundaries (dut 2) ----------------
        valid[2] = 1'b1;
        data[2]  = 8'h11;
        tick();                                   // N
        valid[2] = 1'b0;
        tick();                                   // N+1
        ack[2] = 1'b1;                            // ack_s high in the cycle before N+4
        tick();
        tick();                                   // N+3
        check_eq("t4a_req_n3", 32'(req[2]), 32'd1);
        tick();                                   // N+4: exit beats timeout
        check_eq("t4a_req",  32'(req[2]),  32'd0);
        check_eq("t4a_tout", 32'(tout[2]), 32'd0);
        tick();                                   // N+5
        check_eq("t4a_tout_n5", 32'(tout[2]), 32'd0);
        ack[2] = 1'b0;
        tick();
        tick();
        check_eq("t4a_low_done_n7", 32'(done[2]), 32'd0);
        tick();                                   // N+8: REQ_LOW exit beats timeout
        check_eq("t4a_done",      32'(done[2]),  32'd1);
        check_eq("t4a_low_tout",  32'(tout[2]),  32'd0);
        check_eq("t4a_ready",     32'(ready[2]), 32'd1);
        valid[2] = 1'b1;
        data[2]  = 8'h22;
        tick();                                   // P
        valid[2] = 1'b0;
        tick();
        tick();                                   // P+2
        ack[2] = 1'b1;                            // one cycle too late
        tick();
        check_eq("t4b_tout_p3", 32'(tout[2]), 32'd0);
        tick();                                   // P+4
        check_eq("t4b_tout", 32'(tout[2]), 32'd1);
        check_eq("t4b_req",  32'(req[2]),  32'd0);
        check_eq("t4b_done", 32'(done[2]), 32'd0);
        check_eq("t4b_data", 32'(dout[2]), 32'h22);
        ack[2] = 1'b0;
        repeat (6) tick();

        // ---------------- reset during REQ_HIGH with ack high (dut 1) ----------------
        valid[1] = 1'b1;
        data[1]  = 8'h5A;
        tick();                                   // Q
        valid[1] = 1'b0;
        ack[1]   = 1'b1;
        tick();                                   // Q+1, still REQ_HIGH
        check_eq("mr_req_before", 32'(req[1]), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mr_req",   32'(req[1]),   32'd0);
        check_eq("mr_data",  32'(dout[1]),  32'd0);
        check_eq("mr_ready", 32'(ready[1]), 32'd0);
        check_eq("mr_data0", 32'(dout[0]),  32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("mr_stale_ready", 32'(ready[1]), 32'd0);
        end
        ack[1] = 1'b0;
        tick();
        check_eq("mr_drain1_ready", 32'(ready[1]), 32'd0);
        tick();
        check_eq("mr_drain2_ready", 32'(ready[1]), 32'd0);
        tick();
        check_eq("mr_drain3_ready", 32'(ready[1]), 32'd1);
        check_eq("mr_drain3_req",   32'(req[1]),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
